seq_divider: RTL and testbench

- Sequential shift/subtract (restoring) divider; the inverse of the team's sequential Booth multiplier.
- Divides a 2*WIDTH-bit dividend, e.g. a multiplier product, by a WIDTH-bit divisor.
- Produces a WIDTH-bit quotient and a WIDTH-bit remainder, one quotient bit per clock.
- Uses the same start/ready handshake as the multiplier, so both can share one datapath controller.

---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 198 +++++++++++++++++++
 tb/tb_seq_divider.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider, start/ready handshake.
// The master drives the operands and start; the slave (the divider) drives results and status.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   ready;
    logic                   div_by_zero;
    logic                   overflow;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, ready, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, ready, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift/subtract divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    seq_divider_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CHECK, DIV, FIX} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH:0]     part_rem_reg, part_rem_next;
    logic [WIDTH-1:0]   low_reg, low_next;
    logic [WIDTH-1:0]   divisor_reg, divisor_next;
    logic [CW-1:0]      count_reg, count_next;
    logic               pend_zero_reg, pend_zero_next;
    logic               pend_ovf_reg, pend_ovf_next;
    logic [WIDTH-1:0]   quotient_reg, quotient_next;
    logic [WIDTH-1:0]   remainder_reg, remainder_next;
    logic               ready_reg, ready_next;
    logic               dbz_reg, dbz_next;
    logic               ovf_reg, ovf_next;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};
    logic neg_dd_reg, neg_dd_next;
    logic neg_dv_reg, neg_dv_next;
    logic q_neg;
`endif

    logic [2*WIDTH-1:0] dd_abs;
    logic [WIDTH-1:0]   dv_abs;
    logic [WIDTH+1:0]   rem_shift;
    logic [WIDTH+1:0]   trial;

    always_comb begin
        state_next     = state_reg;
        part_rem_next  = part_rem_reg;
        low_next       = low_reg;
        divisor_next   = divisor_reg;
        count_next     = count_reg;
        pend_zero_next = pend_zero_reg;
        pend_ovf_next  = pend_ovf_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        ready_next     = ready_reg;
        dbz_next       = dbz_reg;
        ovf_next       = ovf_reg;
        dd_abs         = bus.dividend;
        dv_abs         = bus.divisor;
        rem_shift      = {part_rem_reg, low_reg[WIDTH-1]};
        trial          = rem_shift - {2'b00, divisor_reg};
`ifdef DIV_SIGNED_EN
        neg_dd_next    = neg_dd_reg;
        neg_dv_next    = neg_dv_reg;
        q_neg          = neg_dd_reg ^ neg_dv_reg;
        if (bus.dividend[2*WIDTH-1]) begin
            dd_abs = (2*WIDTH)'(0) - bus.dividend;
        end
        if (bus.divisor[WIDTH-1]) begin
            dv_abs = WIDTH'(0) - bus.divisor;
        end
`endif

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    // High half goes straight into the partial remainder; CHECK compares it.
                    part_rem_next = {1'b0, dd_abs[2*WIDTH-1:WIDTH]};
                    low_next      = dd_abs[WIDTH-1:0];
                    divisor_next  = dv_abs;
`ifdef DIV_SIGNED_EN
                    neg_dd_next   = bus.dividend[2*WIDTH-1];
                    neg_dv_next   = bus.divisor[WIDTH-1];
`endif
                    ready_next    = 1'b0;
                    state_next    = CHECK;
                end
            end

            CHECK: begin
                // Errors still pass through FIX so the error path takes two edges end to end.
                pend_zero_next = 1'b0;
                pend_ovf_next  = 1'b0;
                count_next     = '0;
                if (divisor_reg == '0) begin
                    pend_zero_next = 1'b1;
                    state_next     = FIX;
                end else if (part_rem_reg[WIDTH-1:0] >= divisor_reg) begin
                    pend_ovf_next  = 1'b1;
                    state_next     = FIX;
                end else begin
                    state_next     = DIV;
                end
            end

            DIV: begin
                if (!trial[WIDTH+1]) begin
                    part_rem_next = trial[WIDTH:0];
                    low_next      = {low_reg[WIDTH-2:0], 1'b1};
                end else begin
                    part_rem_next = rem_shift[WIDTH:0];
                    low_next      = {low_reg[WIDTH-2:0], 1'b0};
                end
                if (count_reg == LAST_COUNT) begin
                    count_next = '0;
                    state_next = FIX;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end

            FIX: begin
                quotient_next  = '0;
                remainder_next = '0;
                dbz_next       = 1'b0;
                ovf_next       = 1'b0;
                if (pend_zero_reg) begin
                    dbz_next = 1'b1;
                end else if (pend_ovf_reg) begin
                    ovf_next = 1'b1;
                end else begin
`ifdef DIV_SIGNED_EN
                    // A negative quotient may reach one step further than a positive one.
                    if ((!q_neg && (low_reg > POS_MAX)) || (q_neg && (low_reg > NEG_MAX))) begin
                        ovf_next = 1'b1;
                    end else begin
                        quotient_next  = q_neg ? (WIDTH'(0) - low_reg) : low_reg;
                        remainder_next = neg_dd_reg ? (WIDTH'(0) - part_rem_reg[WIDTH-1:0])
                                                    : part_rem_reg[WIDTH-1:0];
                    end
`else
                    quotient_next  = low_reg;
                    remainder_next = part_rem_reg[WIDTH-1:0];
`endif
                end
                pend_zero_next = 1'b0;
                pend_ovf_next  = 1'b0;
                ready_next     = 1'b1;
                state_next     = IDLE;
            end

            default: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            part_rem_reg  <= '0;
            low_reg       <= '0;
            divisor_reg   <= '0;
            count_reg     <= '0;
            pend_zero_reg <= 1'b0;
            pend_ovf_reg  <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            ready_reg     <= 1'b1;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_dd_reg    <= 1'b0;
            neg_dv_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            part_rem_reg  <= part_rem_next;
            low_reg       <= low_next;
            divisor_reg   <= divisor_next;
            count_reg     <= count_next;
            pend_zero_reg <= pend_zero_next;
            pend_ovf_reg  <= pend_ovf_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            ready_reg     <= ready_next;
            dbz_reg       <= dbz_next;
            ovf_reg       <= ovf_next;
`ifdef DIV_SIGNED_EN
            neg_dd_reg    <= neg_dd_next;
            neg_dv_reg    <= neg_dv_next;
`endif
        end
    end

    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.ready       = ready_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.overflow    = ovf_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=8): driver queues expected results, monitor checks each completion.
// Vector table follows DIV_SIGNED_EN so either build is exercised with hand-computed answers.
module tb_seq_divider;
    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] dd;
        logic [W-1:0]   dv;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           dbz;
        logic           ovf;
        int             lat;
    } vec_t;

    logic clk;
    logic rst;
    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   done_count = 0;
    vec_t exp_q[$];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Monitor: counts busy cycles and checks every ready rise against the queue head.
    initial begin : monitor
        int   busy;
        logic prev;
        vec_t e;
        busy = 0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy = 0;
                prev = 1'b1;
            end else begin
                if (!bus.ready) begin
                    busy++;
                end else if (!prev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_completion", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("quotient", int'(bus.quotient), int'(e.q));
                        chk("remainder", int'(bus.remainder), int'(e.r));
                        chk("div_by_zero", int'(bus.div_by_zero), int'(e.dbz));
                        chk("overflow", int'(bus.overflow), int'(e.ovf));
                        chk("latency", busy, e.lat);
                        $display("op %04h / %02h -> q=%02h r=%02h dbz=%0d ovf=%0d lat=%0d",
                                 e.dd, e.dv, bus.quotient, bus.remainder,
                                 bus.div_by_zero, bus.overflow, busy);
                    end
                    done_count++;
                    busy = 0;
                end
                prev = bus.ready;
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 50 && !bus.ready; i++) @(negedge clk);
        if (!bus.ready) chk("wait_ready_timeout", 0, 1);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 40 && done_count < target; i++) @(negedge clk);
        if (done_count < target) begin
            chk("completion_timeout", done_count, target);
            exp_q.delete();
        end
    endtask

    task automatic run_op(input vec_t v);
        int target;
        wait_ready();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = v.dd;
        bus.divisor  = v.dv;
        exp_q.push_back(v);
        target = done_count + 1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = ~v.dd;
        bus.divisor  = v.dv + 8'd3;
        chk("busy_after_accept", int'(bus.ready), 0);
        wait_done(target);
    endtask

    vec_t vecs[$];

    initial begin : driver
        vec_t v;
        int   target;
`ifdef DIV_SIGNED_EN
        vecs.push_back('{16'h0294, 8'd20,  8'h21, 8'h00, 1'b0, 1'b0, 10});
        vecs.push_back('{16'hFD6B, 8'd20,  8'hDF, 8'hFF, 1'b0, 1'b0, 10});
        vecs.push_back('{16'd100,  8'd0,   8'h00, 8'h00, 1'b1, 1'b0, 2});
        vecs.push_back('{16'h0294, 8'd20,  8'h21, 8'h00, 1'b0, 1'b0, 10});
        vecs.push_back('{16'h4000, 8'd64,  8'h00, 8'h00, 1'b0, 1'b1, 2});
        vecs.push_back('{16'h0294, 8'd20,  8'h21, 8'h00, 1'b0, 1'b0, 10});
        vecs.push_back('{16'h2000, 8'd64,  8'h00, 8'h00, 1'b0, 1'b1, 10});
        vecs.push_back('{16'h0294, 8'd20,  8'h21, 8'h00, 1'b0, 1'b0, 10});
        vecs.push_back('{16'hE000, 8'd64,  8'h80, 8'h00, 1'b0, 1'b0, 10});
        vecs.push_back('{16'hFF9C, 8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 10});
        vecs.push_back('{16'h0064, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 10});
`else
        vecs.push_back('{16'h0294, 8'd20,  8'h21, 8'h00, 1'b0, 1'b0, 10});
        vecs.push_back('{16'hFD6B, 8'd20,  8'h00, 8'h00, 1'b0, 1'b1, 2});
        vecs.push_back('{16'd100,  8'd0,   8'h00, 8'h00, 1'b1, 1'b0, 2});
        vecs.push_back('{16'h0294, 8'd20,  8'h21, 8'h00, 1'b0, 1'b0, 10});
        vecs.push_back('{16'h4000, 8'd64,  8'h00, 8'h00, 1'b0, 1'b1, 2});
        vecs.push_back('{16'h2000, 8'd64,  8'h80, 8'h00, 1'b0, 1'b0, 10});
        vecs.push_back('{16'h03E8, 8'd7,   8'h8E, 8'h06, 1'b0, 1'b0, 10});
        vecs.push_back('{16'hFE01, 8'hFF,  8'hFF, 8'h00, 1'b0, 1'b0, 10});
        vecs.push_back('{16'h00FF, 8'h10,  8'h0F, 8'h0F, 1'b0, 1'b0, 10});
`endif
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset_ready", int'(bus.ready), 1);
        chk("reset_quotient", int'(bus.quotient), 0);
        chk("reset_remainder", int'(bus.remainder), 0);
        chk("reset_flags", int'({bus.div_by_zero, bus.overflow}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // Abort mid-operation: outputs must drop to reset values without a clock edge.
        wait_ready();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'h00FF;
        bus.divisor  = 8'h10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_ready", int'(bus.ready), 1);
        chk("abort_quotient", int'(bus.quotient), 0);
        chk("abort_remainder", int'(bus.remainder), 0);
        chk("abort_flags", int'({bus.div_by_zero, bus.overflow}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_op('{16'h0294, 8'd20, 8'h21, 8'h00, 1'b0, 1'b0, 10});

        // Two-cycle start plus a pulse while busy must give exactly one operation.
        wait_ready();
        v = '{16'h0294, 8'd20, 8'h21, 8'h00, 1'b0, 1'b0, 10};
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = v.dd;
        bus.divisor  = v.dv;
        exp_q.push_back(v);
        target = done_count + 1;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(target);
        repeat (20) @(negedge clk);
        chk("single_op_count", done_count, target);
        chk("single_op_ready", int'(bus.ready), 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
